// File: rtl/jc_step_sequencer.sv
// jc_step_sequencer
//   Command-driven sequencer for a WIDTH-bit Johnson (twisted-ring) counter.
//   A control master hands over {direction, step count} on a valid/ready
//   handshake; the ring is then stepped that many times (pause holds it,
//   abort ends the command early). The ring state, its decoded phase index
//   and done/aborted/wrap status are reported to the consumer.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      command can be accepted (IDLE)
//   cmd_dir    in   1      0 = forward, 1 = reverse
//   cmd_steps  in   CNTW   number of ring steps to run
//   pause      in   1      hold ring and step counter (RUN only)
//   abort      in   1      end the current command early (RUN only)
//   q          out  WIDTH  Johnson register state
//   phase      out  PHW    phase index 0..2*WIDTH-1, combinational from q
//   busy       out  1      command in progress
//   done       out  1      one-cycle pulse, command finished
//   aborted    out  1      qualifies done: command ended by abort
//   wrap       out  1      one-cycle pulse after a step across 2W-1 <-> 0
module jc_step_sequencer #(
    parameter int WIDTH = 64,
    parameter int CNTW  = 16,
    localparam int PHW  = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNTW-1:0]  cmd_steps,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic [PHW-1:0]   phase,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             wrap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [PHW-1:0] LAST_PHASE = PHW'(2*WIDTH - 1);

    state_t          state, state_nxt;
    logic [CNTW-1:0] remaining;
    logic            dir_r;
    logic            accept;
    logic            step_en;
    logic            abort_hit;
    logic            wrap_hit;
    logic [PHW-1:0]  ones_cnt;

    function automatic logic [PHW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PHW-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + PHW'(v[i]);
        end
        return c;
    endfunction

    // Phase decode: the first half of the ring fills ones from the MSB down
    // (phase = count), the second half drains them from the MSB down, which
    // leaves the MSB clear with a nonzero count (phase = 2W - count).
    assign ones_cnt = popcount(q);

    always_comb begin
        if (q[WIDTH-1] || (q == '0)) begin
            phase = ones_cnt;
        end else begin
            phase = LAST_PHASE - ones_cnt + PHW'(1);
        end
    end

    // A forward step out of phase 2W-1 or a reverse step out of phase 0
    // crosses the ring seam.
    assign wrap_hit = dir_r ? (phase == '0) : (phase == LAST_PHASE);

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step_en   = 1'b0;
        abort_hit = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = (cmd_steps == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // abort outranks pause and suppresses the step of its cycle
                if (abort) begin
                    abort_hit = 1'b1;
                    state_nxt = DONE;
                end else if (!pause) begin
                    step_en = 1'b1;
                    if (remaining == CNTW'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            dir_r     <= 1'b0;
            q         <= '0;
            aborted   <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                dir_r     <= cmd_dir;
                remaining <= cmd_steps;
            end else if (step_en) begin
                remaining <= remaining - CNTW'(1);
            end

            if (step_en) begin
                q <= dir_r ? {q[WIDTH-2:0], ~q[WIDTH-1]}
                           : {~q[0], q[WIDTH-1:1]};
            end

            wrap <= step_en && wrap_hit;

            // held through the DONE cycle, dropped on the way back to IDLE
            if (abort_hit) begin
                aborted <= 1'b1;
            end else if (state == DONE) begin
                aborted <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jc_step_sequencer.sv
module tb_jc_step_sequencer;

    localparam int W    = 64;
    localparam int CW   = 16;
    localparam int PW   = 7;
    localparam int RING = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_dir = 1'b0;
    logic [CW-1:0] cmd_steps = '0;
    logic          pause = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  q;
    logic [PW-1:0] phase;
    logic          busy;
    logic          done;
    logic          aborted;
    logic          wrap;

    int nchk  = 0;
    int nfail = 0;
    int mp    = 0;   // model ring position, 0..2W-1

    always #5 clk = ~clk;

    jc_step_sequencer #(.WIDTH(W), .CNTW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_steps (cmd_steps),
        .pause     (pause),
        .abort     (abort),
        .q         (q),
        .phase     (phase),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .wrap      (wrap)
    );

    typedef struct {
        bit          dir;
        int          steps;
        int          ps;        // first edge index with pause high (0 = none)
        int          pl;        // number of paused edges
        int          ab;        // edge index with abort high (0 = none)
        int          exp_phase;
        logic [63:0] exp_q;
        int          exp_lat;   // edges from accept to the done cycle
        bit          exp_ab;
        bit          exp_wrap;  // wrap seen in the done cycle
    } vec_t;

    vec_t tbl[10];

    // Ring position p maps to: p<=W -> p ones from the MSB; p>W -> 2W-p ones at the LSB end.
    function automatic logic [W-1:0] q_of_phase(input int p);
        logic [W-1:0] ones;
        ones = '1;
        if (p <= W) return ~(ones >> p);
        return ones >> (W - (RING - p));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input bit dir, input int steps, input int ps, input int pl,
                           input int ab_at, input bit rnd,
                           output int lat, output bit ab_seen, output bit wrap_seen,
                           output logic [W-1:0] q_seen);
        int rem;
        int e;
        bit mdone, mab, mwrap, pin, ain, fin;
        lat = -1; ab_seen = 0; wrap_seen = 0; q_seen = '0;
        chk("ready_idle", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_steps = CW'(steps);
        pause     = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        abort     = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        rem = steps; e = 0; fin = 0;
        mdone = (steps == 0); mab = 0; mwrap = 0;
        cmd_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        if (rnd) cmd_steps = CW'($urandom_range(0, 5));
        while (!fin) begin
            chk("q", q, q_of_phase(mp));
            chk("phase", 64'(phase), 64'(mp));
            chk("wrap", 64'(wrap), 64'(mwrap));
            chk("busy", 64'(busy), 64'(1));
            chk("ready_busy", 64'(cmd_ready), 64'(0));
            chk("done", 64'(done), 64'(mdone));
            if (mdone) begin
                chk("aborted", 64'(aborted), 64'(mab));
                lat = e; ab_seen = aborted; wrap_seen = wrap; q_seen = q;
                pause = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                abort = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                tick();
                cmd_valid = 1'b0; pause = 1'b0; abort = 1'b0;
                chk("busy_end", 64'(busy), 64'(0));
                chk("ready_end", 64'(cmd_ready), 64'(1));
                chk("done_end", 64'(done), 64'(0));
                chk("aborted_end", 64'(aborted), 64'(0));
                chk("wrap_end", 64'(wrap), 64'(0));
                chk("q_end", q, q_of_phase(mp));
                fin = 1;
            end else if (e > 4 * steps + pl + 200) begin
                nchk++; nfail++;
                $display("FAIL timeout: no done after %0d cycles, expected done", e);
                cmd_valid = 1'b0; pause = 1'b0; abort = 1'b0;
                fin = 1;
            end else begin
                if (rnd) begin
                    pin = ($urandom_range(0, 3) == 0);
                    ain = ($urandom_range(0, 60) == 0);
                end else begin
                    pin = (e + 1 >= ps) && (e + 1 < ps + pl);
                    ain = (e + 1 == ab_at);
                end
                pause = pin; abort = ain;
                tick();
                e++;
                if (ain) begin
                    mdone = 1; mab = 1; mwrap = 0;
                end else if (pin) begin
                    mwrap = 0;
                end else begin
                    mwrap = dir ? (mp == 0) : (mp == RING - 1);
                    mp = dir ? (mp + RING - 1) % RING : (mp + 1) % RING;
                    rem--;
                    if (rem == 0) mdone = 1;
                end
            end
        end
    endtask

    initial begin
        int lat;
        bit ab_s, wr_s;
        logic [W-1:0] q_s;

        tbl[0] = '{0, 20, 0, 0, 0,  20, 64'hFFFF_F000_0000_0000, 20, 0, 0};
        tbl[1] = '{0, 44, 0, 0, 0,  64, 64'hFFFF_FFFF_FFFF_FFFF, 44, 0, 0};
        tbl[2] = '{0,  1, 0, 0, 0,  65, 64'h7FFF_FFFF_FFFF_FFFF,  1, 0, 0};
        tbl[3] = '{0, 63, 0, 0, 0,   0, 64'h0000_0000_0000_0000, 63, 0, 1};
        tbl[4] = '{1,  1, 0, 0, 0, 127, 64'h0000_0000_0000_0001,  1, 0, 1};
        tbl[5] = '{0, 10, 5, 3, 0,   9, 64'hFF80_0000_0000_0000, 13, 0, 0};
        tbl[6] = '{0, 10, 0, 0, 5,  13, 64'hFFF8_0000_0000_0000,  5, 1, 0};
        tbl[7] = '{0,  0, 0, 0, 0,  13, 64'hFFF8_0000_0000_0000,  0, 0, 0};
        tbl[8] = '{0,  5, 2, 10, 3, 14, 64'hFFFC_0000_0000_0000,  3, 1, 0};
        tbl[9] = '{1, 20, 0, 0, 0, 122, 64'h0000_0000_0000_003F, 20, 0, 0};

        // reset held for two cycles
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_q", q, 64'h0);
        chk("rst_phase", 64'(phase), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_aborted", 64'(aborted), 64'(0));
        chk("rst_wrap", 64'(wrap), 64'(0));
        rst_n = 1'b1;
        tick();
        chk("rst_ready", 64'(cmd_ready), 64'(1));
        mp = 0;

        for (int i = 0; i < 10; i++) begin
            run_cmd(tbl[i].dir, tbl[i].steps, tbl[i].ps, tbl[i].pl, tbl[i].ab, 1'b0,
                    lat, ab_s, wr_s, q_s);
            chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].exp_lat));
            chk($sformatf("tbl%0d_aborted", i), 64'(ab_s), 64'(tbl[i].exp_ab));
            chk($sformatf("tbl%0d_wrap", i), 64'(wr_s), 64'(tbl[i].exp_wrap));
            chk($sformatf("tbl%0d_q", i), q_s, tbl[i].exp_q);
            chk($sformatf("tbl%0d_phase", i), 64'(phase), 64'(tbl[i].exp_phase));
        end

        // reset pulsed in the middle of a run: immediate return, no done afterwards
        cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_steps = CW'(30);
        tick();
        cmd_valid = 1'b0;
        repeat (5) tick();
        chk("mid_busy_before", 64'(busy), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_q", q, 64'h0);
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        chk("mid_rst_ready", 64'(cmd_ready), 64'(1));
        tick();
        rst_n = 1'b1;
        mp = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("post_rst_done", 64'(done), 64'(0));
            chk("post_rst_busy", 64'(busy), 64'(0));
        end
        chk("post_rst_q", q, 64'h0);

        // randomized commands against the ring-position model
        for (int i = 0; i < 25; i++) begin
            run_cmd(1'($urandom_range(0, 1)), $urandom_range(0, 150), 0, 0, 0, 1'b1,
                    lat, ab_s, wr_s, q_s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
